// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_pkg
//  Description : Shared definitions for the USB token-field transmitter:
//                token state encoding, CRC5 polynomial/preset and field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    localparam int ADDR_W    = 7;
    localparam int ENDP_W    = 4;
    localparam int CRC5_W    = 5;
    localparam int DATA_BITS = ADDR_W + ENDP_W;

    // x^5 + x^2 + 1, with the x^5 term implied by the shift-out
    localparam logic [CRC5_W-1:0] CRC5_POLY = 5'b00101;
    localparam logic [CRC5_W-1:0] CRC5_INIT = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/crc5_gen.sv
`default_nettype none
// ============================================================================
//  Module      : crc5_gen
//  Description : Serial CRC5 LFSR, one data bit per enabled cycle.
//  Ports       : clk     - clock
//                nRst    - asynchronous active-low reset (to CRC5_INIT)
//                preset  - load CRC5_INIT (wins over enable)
//                enable  - fold din into the register this cycle
//                din     - serial data bit
//                crc     - current register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module crc5_gen
    import usb_pkg::*;
(
    input  logic              clk,
    input  logic              nRst,
    input  logic              preset,
    input  logic              enable,
    input  logic              din,
    output logic [CRC5_W-1:0] crc
);

    logic [CRC5_W-1:0] crc_q;
    logic [CRC5_W-1:0] crc_d;
    logic              fb;

    always_comb begin
        fb    = din ^ crc_q[CRC5_W-1];
        crc_d = crc_q;
        if (preset) begin
            crc_d = CRC5_INIT;
        end else if (enable) begin
            crc_d = {crc_q[CRC5_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            crc_q <= CRC5_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/crc5_token_tx.sv
`default_nettype none
// ============================================================================
//  Module      : crc5_token_tx
//  Description : Serialises a USB token field (addr, endp, inverted CRC5)
//                as NRZ bits, one bit per shift_en strobe.
//  Ports       : clk, nRst        - clock, asynchronous active-low reset
//                start            - send request (accepted only in IDLE)
//                addr[6:0]        - device address, latched on accept
//                endp[3:0]        - endpoint, latched on accept
//                shift_en         - advance to next bit
//                abort            - cancel current field, back to IDLE
//                tx_bit           - current serial bit (0 when not valid)
//                tx_valid         - tx_bit carries a field bit
//                busy             - not IDLE
//                done             - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module crc5_token_tx
    import usb_pkg::*;
(
    input  logic              clk,
    input  logic              nRst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ENDP_W-1:0] endp,
    input  logic              shift_en,
    input  logic              abort,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_CRC  = 4'(CRC5_W - 1);

    tx_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ENDP_W-1:0] endp_q, endp_d;

    logic                 crc_preset;
    logic                 crc_enable;
    logic [CRC5_W-1:0]    crc;
    logic [DATA_BITS-1:0] field;
    logic                 data_bit;
    logic                 crc_bit;

    // Address occupies the low bits so that counter order equals wire order.
    assign field    = {endp_q, addr_q};
    assign data_bit = field[cnt_q];

    // CRC goes out MSB first and inverted; counter restarts at 0 for this phase.
    always_comb begin
        crc_bit = 1'b0;
        case (cnt_q[2:0])
            3'd0:    crc_bit = ~crc[4];
            3'd1:    crc_bit = ~crc[3];
            3'd2:    crc_bit = ~crc[2];
            3'd3:    crc_bit = ~crc[1];
            3'd4:    crc_bit = ~crc[0];
            default: crc_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        endp_d     = endp_q;
        crc_preset = 1'b0;
        crc_enable = 1'b0;
        tx_bit     = 1'b0;
        tx_valid   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    addr_d     = addr;
                    endp_d     = endp;
                    cnt_d      = 4'd0;
                    crc_preset = 1'b1;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_bit   = data_bit;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (shift_en) begin
                    crc_enable = 1'b1;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = 4'd0;
                        state_d = ST_CRC;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_CRC: begin
                tx_valid = 1'b1;
                tx_bit   = crc_bit;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (shift_en) begin
                    if (cnt_q == LAST_CRC) begin
                        cnt_d   = 4'd0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            endp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            endp_q  <= endp_d;
        end
    end

    crc5_gen u_crc5_gen (
        .clk    (clk),
        .nRst   (nRst),
        .preset (crc_preset),
        .enable (crc_enable),
        .din    (data_bit),
        .crc    (crc)
    );

endmodule
`default_nettype wire
